seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per clock, LSB chunk first, with a carry register between chunks. It adds carry-in, subtract mode, unsigned saturation and carry/signed-overflow flags, all under a start/busy/done handshake. It serves the lab datapaths as the arithmetic unit wherever a narrow, slow carry chain is preferred over one wide combinational adder.

---
 rtl/seq_chunk_adder_pkg.sv | 7 +
 rtl/seq_chunk_adder_if.sv | 7 +
 rtl/seq_chunk_adder_chunk_add.sv | 10 +
 rtl/seq_chunk_adder.sv | 71 +++++++
 tb/tb_seq_chunk_adder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// adder_pkg: shared state encoding and index-width helper for seq_chunk_adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: start/busy/done handshake, operands, mode bits and result flags
interface seq_chunk_adder_if #(parameter int WIDTH = 8);
  logic start, cin, sub, sat, busy, done, cout, ovf;
  logic [WIDTH-1:0] input1, input2, out;
  modport master(output start, input1, input2, cin, sub, sat, input busy, done, out, cout, ovf);
  modport slave(input start, input1, input2, cin, sub, sat, output busy, done, out, cout, ovf);
endinterface

// File: rtl/seq_chunk_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit adder (a, b, ci in; s, co out)
module chunk_add #(parameter int CHUNK = 4) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(ci);
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per clock; ports clk, rst, bus (slave: start/operands/mode in, busy/done/out/cout/ovf out)
module seq_chunk_adder import adder_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = idx_w(NCHUNK);
  if (WIDTH <= 0 || WIDTH % CHUNK != 0) begin : g_chk
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end
  state_t state, nstate;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic [IW-1:0] idx;
  logic carry, sub_r, sat_r, cout_r, ovf_r, last, co;
  logic [CHUNK-1:0] s;
  chunk_add #(.CHUNK(CHUNK)) u_add (
    .a(a_r[idx*CHUNK +: CHUNK]),
    .b(b_r[idx*CHUNK +: CHUNK]),
    .ci(carry),
    .s(s),
    .co(co)
  );
  assign last = idx == IW'(NCHUNK - 1);
  always_comb begin
    nstate = IDLE;
    nstate = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      res    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      sat_r  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= nstate;
      if (state != RUN && bus.start) begin
        a_r   <= bus.input1;
        b_r   <= bus.sub ? ~bus.input2 : bus.input2;
        carry <= bus.sub | bus.cin;
        sub_r <= bus.sub;
        sat_r <= bus.sat;
        idx   <= '0;
      end else if (state == RUN) begin
        res[idx*CHUNK +: CHUNK] <= s;
        carry <= co;
        idx   <= idx + 1'b1;
        if (last) begin
          cout_r <= co;
          ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s[CHUNK-1] != a_r[WIDTH-1]);
          // add overflow (carry) or sub underflow (no carry) clamps; this overrides the slice write
          if (sat_r && (co ^ sub_r)) res <= sub_r ? '0 : '1;
        end
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.out  = res;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: randomized and directed checks of 8-bit and 16-bit seq_chunk_adder against an arithmetic model
module tb_seq_chunk_adder;
  logic clk = 0, rst = 1, start = 0, cin = 0, sub = 0, sat = 0, wide = 0;
  logic [15:0] a = 0, b = 0;
  int errors = 0, checks = 0;
  seq_chunk_adder_if #(.WIDTH(8)) i8 ();
  seq_chunk_adder_if #(.WIDTH(16)) i16 ();
  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) d8 (.clk(clk), .rst(rst), .bus(i8.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) d16 (.clk(clk), .rst(rst), .bus(i16.slave));
  assign i8.start = start & ~wide;
  assign i8.input1 = a[7:0];
  assign i8.input2 = b[7:0];
  assign i8.cin = cin;
  assign i8.sub = sub;
  assign i8.sat = sat;
  assign i16.start = start & wide;
  assign i16.input1 = a;
  assign i16.input2 = b;
  assign i16.cin = cin;
  assign i16.sub = sub;
  assign i16.sat = sat;
  logic busy_o, done_o, cout_o, ovf_o;
  logic [15:0] out_o;
  assign busy_o = wide ? i16.busy : i8.busy;
  assign done_o = wide ? i16.done : i8.done;
  assign cout_o = wide ? i16.cout : i8.cout;
  assign ovf_o  = wide ? i16.ovf : i8.ovf;
  assign out_o  = wide ? i16.out : {8'h00, i8.out};
  always #5 clk = ~clk;

  function automatic void model(input int w, input longint x, input longint y, input bit ci,
                                input bit sb, input bit st, output longint o, output bit co, output bit ov);
    longint m, sx, sy, r, raw;
    m = longint'(1) << w;
    sx = x >= m / 2 ? x - m : x;
    sy = y >= m / 2 ? y - m : y;
    if (sb) begin
      r = sx - sy;
      co = x >= y;
      raw = (x - y + m) % m;
    end else begin
      r = sx + sy + longint'(ci);
      co = x + y + longint'(ci) >= m;
      raw = (x + y + longint'(ci)) % m;
    end
    ov = r >= m / 2 || r < -(m / 2);
    o = (st && !sb && co) ? m - 1 : (st && sb && !co) ? 0 : raw;
  endfunction

  task automatic op(input bit w16, input logic [15:0] x, input logic [15:0] y, input bit ci,
                    input bit sb, input bit st, input int gap, input bit poke);
    longint eo;
    bit ec, ev;
    int n, nch;
    logic [15:0] xm, ym;
    xm = w16 ? x : {8'h00, x[7:0]};
    ym = w16 ? y : {8'h00, y[7:0]};
    nch = w16 ? 4 : 2;
    start = 0;
    wide = w16;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    if (gap > 0) begin
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0)
        $display("FAIL idle_after_done: busy=%b done=%b expected 0 0", busy_o, done_o);
    end
    if (gap > 0 && errors < 0) errors = 0;
    a = xm; b = ym; cin = ci; sub = sb; sat = st; start = 1;
    @(posedge clk); #1;
    start = 0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    n = 1;
    while (done_o !== 1'b1 && n <= nch + 3) begin
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy_run: cycle %0d busy=%b expected 1", n, busy_o);
      end
      start = poke;
      if (poke) begin a = 16'($urandom); b = 16'($urandom); end
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    checks++;
    if (done_o !== 1'b1 || n != nch + 1) begin
      errors++;
      $display("FAIL latency: done=%b after %0d cycles expected 1 after %0d", done_o, n, nch + 1);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: busy=%b expected 0", busy_o);
    end
    model(w16 ? 16 : 8, longint'(xm), longint'(ym), ci, sb, st, eo, ec, ev);
    checks++;
    if (out_o !== 16'(eo)) begin
      errors++;
      $display("FAIL out: %0h %s %0h cin=%b sat=%b got %0h expected %0h", xm, sb ? "-" : "+", ym, ci, st, out_o, 16'(eo));
    end
    checks++;
    if (cout_o !== ec) begin
      errors++;
      $display("FAIL cout: %0h %s %0h got %b expected %b", xm, sb ? "-" : "+", ym, cout_o, ec);
    end
    checks++;
    if (ovf_o !== ev) begin
      errors++;
      $display("FAIL ovf: %0h %s %0h got %b expected %b", xm, sb ? "-" : "+", ym, ovf_o, ev);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({i8.busy, i8.done, i8.cout, i8.ovf, i8.out} !== 12'h0) begin
      errors++;
      $display("FAIL reset8: busy/done/cout/ovf/out=%0h expected 0", {i8.busy, i8.done, i8.cout, i8.ovf, i8.out});
    end
    checks++;
    if ({i16.busy, i16.done, i16.cout, i16.ovf, i16.out} !== 20'h0) begin
      errors++;
      $display("FAIL reset16: busy/done/cout/ovf/out=%0h expected 0", {i16.busy, i16.done, i16.cout, i16.ovf, i16.out});
    end
    rst = 0;
  endtask

  task automatic test_directed();
    op(0, 15, 20, 0, 0, 0, 1, 0);
    op(0, 254, 1, 1, 0, 0, 1, 0);
    op(0, 254, 1, 1, 0, 1, 1, 0);
    op(0, 100, 28, 0, 1, 0, 1, 0);
    op(0, 5, 10, 0, 1, 0, 1, 0);
    op(0, 5, 10, 0, 1, 1, 1, 0);
    op(0, 100, 28, 0, 0, 0, 1, 0);
    op(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_ignore_start();
    op(0, 77, 99, 1, 0, 0, 1, 1);
    op(1, 16'h1234, 16'h4321, 0, 1, 0, 1, 1);
  endtask

  task automatic test_back_to_back();
    op(0, 200, 100, 0, 0, 0, 2, 0);
    op(0, 3, 9, 0, 1, 0, 0, 0);
    op(0, 128, 128, 0, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    op(0, 200, 17, 0, 0, 0, 1, 0);
    a = 16'd50; b = 16'd60; cin = 0; sub = 0; sat = 0; start = 1;
    @(posedge clk); #1;
    start = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if ({busy_o, done_o, cout_o, ovf_o, out_o} !== 20'h0) begin
      errors++;
      $display("FAIL rst_mid_run: busy/done/cout/ovf/out=%0h expected 0", {busy_o, done_o, cout_o, ovf_o, out_o});
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_rst: cycle %0d done=%b expected 0", i, done_o);
      end
      @(posedge clk); #1;
    end
    rst = 1; start = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_start: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_wide();
    op(1, 16'hFFFF, 16'h0001, 0, 0, 0, 1, 0);
    op(1, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 0);
    op(1, 16'h8000, 16'h0001, 0, 1, 0, 0, 0);
    op(1, 16'h0003, 16'h0004, 0, 1, 1, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
